// File: rtl/xpb_accum.sv
// Accumulates a seed (low product part) plus a stream of xpb table terms into
// a widened sum, then holds the result under ready/valid backpressure.
module xpb_accum #(
  parameter int DATA_W    = 1024,
  parameter int MAX_TERMS = 32,
  parameter int OUT_W     = DATA_W + $clog2(MAX_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] lo_in,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              busy,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              err_overflow
);

  localparam int CNT_W = $clog2(MAX_TERMS + 1);
  localparam int PAD_W = OUT_W - DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [OUT_W-1:0]   acc_r, acc_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               err_r, err_s;
  logic               busy_r, valid_r;

  // Next-state and datapath update; the final term index is MAX_TERMS-1.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    err_s   = err_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          acc_s   = {{PAD_W{1'b0}}, lo_in};
          cnt_s   = {CNT_W{1'b0}};
          err_s   = 1'b0;
          state_s = ACC;
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_s = acc_r + {{PAD_W{1'b0}}, in_data};
          cnt_s = cnt_r + CNT_W'(1);
          if (in_last) begin
            state_s = HOLD;
          end else if (cnt_r == CNT_W'(MAX_TERMS - 1)) begin
            err_s   = 1'b1;
            state_s = HOLD;
          end else begin
            state_s = ACC;
          end
        end else begin
          state_s = ACC;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, accumulator and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_r   <= {OUT_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
      busy_r  <= (state_s != IDLE);
      valid_r <= (state_s == HOLD);
    end
  end

  assign busy         = busy_r;
  assign out_valid    = valid_r;
  assign out_data     = acc_r;
  assign err_overflow = err_r;

endmodule

// File: tb/tb_xpb_accum.sv
// Bench for xpb_accum: table-driven reductions plus hand-written corner cases,
// expected results queued at stimulus time and compared when out_valid rises.
module tb_xpb_accum;

  localparam int DW = 1024;
  localparam int MT = 32;
  localparam int OW = DW + 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] lo_in;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          busy;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_ready;
  logic          err_overflow;

  xpb_accum #(.DATA_W(DW), .MAX_TERMS(MT), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lo_in(lo_in),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .busy(busy), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    int          n;
    logic [31:0] t0, t1, t2, t3;
    bit          gap;
    bit          coll;
    logic [63:0] exp;
  } vec_t;

  typedef struct packed {
    logic [OW-1:0] d;
    logic          e;
  } exp_t;

  vec_t vecs [6];
  exp_t sb_q [$];
  int   total = 0;
  int   bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h_%h exp=%h_%h", nm, act[OW-1:OW-64], act[63:0],
               exp[OW-1:OW-64], exp[63:0]);
    end
  endtask

  function automatic logic [31:0] term_of(input vec_t v, input int k);
    case (k)
      0:       return v.t0;
      1:       return v.t1;
      2:       return v.t2;
      default: return v.t3;
    endcase
  endfunction

  task automatic do_start(input logic [DW-1:0] lo, input logic coll);
    start    = 1'b1;
    lo_in    = lo;
    in_valid = coll;
    in_data  = DW'(100);
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send_term(input logic [DW-1:0] d, input logic last, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = DW'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // out_valid must already be high right after the last term's edge.
  task automatic wait_result(input string nm);
    exp_t e;
    int   w;
    chk({nm, "_latency"}, OW'(out_valid), OW'(1));
    w = 0;
    while (!out_valid && w < 20) begin
      tick();
      w++;
    end
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_scoreboard act=empty exp=entry", nm);
    end else begin
      e = sb_q.pop_front();
      chk({nm, "_data"}, out_data, e.d);
      chk({nm, "_err"}, OW'(err_overflow), OW'(e.e));
    end
  endtask

  task automatic accept(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_valid_drop"}, OW'(out_valid), OW'(0));
    chk({nm, "_busy_drop"}, OW'(busy), OW'(0));
  endtask

  initial begin
    logic [OW-1:0] full;
    logic [OW-1:0] held;

    vecs[0] = '{lo: 32'd5,   n: 3, t0: 32'd3,  t1: 32'd7,  t2: 32'd9,  t3: 32'd0,
                gap: 1'b0, coll: 1'b0, exp: 64'd24};
    vecs[1] = '{lo: 32'd0,   n: 1, t0: 32'd0,  t1: 32'd0,  t2: 32'd0,  t3: 32'd0,
                gap: 1'b0, coll: 1'b0, exp: 64'd0};
    vecs[2] = '{lo: 32'd100, n: 2, t0: 32'd1,  t1: 32'd2,  t2: 32'd0,  t3: 32'd0,
                gap: 1'b1, coll: 1'b1, exp: 64'd103};
    vecs[3] = '{lo: 32'hFFFF_FFFF, n: 4, t0: 32'hFFFF_FFFF, t1: 32'hFFFF_FFFF,
                t2: 32'hFFFF_FFFF, t3: 32'hFFFF_FFFF, gap: 1'b1, coll: 1'b0,
                exp: 64'h4_FFFF_FFFB};
    vecs[4] = '{lo: 32'd0,   n: 4, t0: 32'd10, t1: 32'd20, t2: 32'd30, t3: 32'd40,
                gap: 1'b1, coll: 1'b1, exp: 64'd100};
    vecs[5] = '{lo: 32'd7,   n: 1, t0: 32'd9,  t1: 32'd0,  t2: 32'd0,  t3: 32'd0,
                gap: 1'b0, coll: 1'b1, exp: 64'd16};

    rst_n = 1'b0; start = 1'b0; lo_in = '0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_busy", OW'(busy), OW'(0));
    chk("rst_valid", OW'(out_valid), OW'(0));
    chk("rst_data", out_data, OW'(0));
    chk("rst_err", OW'(err_overflow), OW'(0));
    #11 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v = vecs[i];
      do_start(DW'(v.lo), v.coll);
      sb_q.push_back('{d: OW'(v.exp), e: 1'b0});
      chk($sformatf("vec%0d_busy", i), OW'(busy), OW'(1));
      for (int k = 0; k < v.n; k++)
        send_term(DW'(term_of(v, k)), (k == v.n - 1), v.gap ? int'($urandom_range(0, 3)) : 0);
      wait_result($sformatf("vec%0d", i));
      accept($sformatf("vec%0d", i));
    end

    // Full-scale: seed and 32 terms all at the maximum value.
    full = {6'b0, {DW{1'b1}}};
    do_start({DW{1'b1}}, 1'b0);
    sb_q.push_back('{d: full * OW'(33), e: 1'b0});
    for (int k = 0; k < MT; k++)
      send_term({DW{1'b1}}, (k == MT - 1), 0);
    wait_result("fullscale");
    accept("fullscale");

    // Truncation at MAX_TERMS without in_last.
    do_start('0, 1'b0);
    sb_q.push_back('{d: OW'(32), e: 1'b1});
    for (int k = 0; k < MT; k++) begin
      send_term(DW'(1), 1'b0, 0);
      if (k == MT - 2) chk("trunc_not_early", OW'(out_valid), OW'(0));
    end
    wait_result("trunc");
    send_term(DW'(1), 1'b0, 0);
    chk("trunc_33rd_data", out_data, OW'(32));
    chk("trunc_33rd_valid", OW'(out_valid), OW'(1));
    accept("trunc");
    tick();
    chk("trunc_err_idle", OW'(err_overflow), OW'(1));
    do_start(DW'(4), 1'b0);
    chk("trunc_err_clear", OW'(err_overflow), OW'(0));
    sb_q.push_back('{d: OW'(5), e: 1'b0});
    send_term(DW'(1), 1'b1, 1);
    wait_result("after_trunc");
    accept("after_trunc");

    // Backpressure with start and in_valid toggling while held.
    do_start(DW'(10), 1'b0);
    sb_q.push_back('{d: OW'(15), e: 1'b0});
    send_term(DW'(5), 1'b1, 0);
    wait_result("bp");
    held = out_data;
    for (int c = 0; c < 10; c++) begin
      start    = c[0];
      lo_in    = DW'(77);
      in_valid = ~c[0];
      in_data  = DW'(7);
      in_last  = 1'b1;
      tick();
      chk($sformatf("bp_hold%0d_data", c), out_data, OW'(15));
      chk($sformatf("bp_hold%0d_valid", c), OW'(out_valid), OW'(1));
      chk($sformatf("bp_hold%0d_busy", c), OW'(busy), OW'(1));
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("bp_stable", out_data, held);
    accept("bp");

    // Asynchronous reset mid-accumulation.
    do_start(DW'(50), 1'b0);
    send_term(DW'(3), 1'b0, 0);
    send_term(DW'(4), 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", OW'(busy), OW'(0));
    chk("arst_valid", OW'(out_valid), OW'(0));
    chk("arst_data", out_data, OW'(0));
    chk("arst_err", OW'(err_overflow), OW'(0));
    #3 rst_n = 1'b1;
    in_valid = 1'b1; in_data = DW'(9); in_last = 1'b1;
    tick();
    tick();
    chk("arst_wait_busy", OW'(busy), OW'(0));
    chk("arst_wait_valid", OW'(out_valid), OW'(0));
    in_valid = 1'b0; in_last = 1'b0;
    do_start(DW'(1), 1'b0);
    sb_q.push_back('{d: OW'(2), e: 1'b0});
    send_term(DW'(1), 1'b1, 0);
    wait_result("arst_after");
    accept("arst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xpb_accum.md
XPB_ACCUM -- requirements
Module: xpb_accum

Interface
REQ-001 Parameter DATA_W, default 1024, SHALL set the width of one xpb table term and of the seed operand.
REQ-002 Parameter MAX_TERMS, default 32, SHALL set the maximum number of terms accepted per reduction.
REQ-003 Parameter OUT_W, default DATA_W+6 (= DATA_W + clog2(MAX_TERMS+1)), SHALL set the accumulator and result width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  input  1  SHALL be a one-cycle request to begin a reduction.
REQ-007 lo_in  input  DATA_W  SHALL be the low product part, sampled with start.
REQ-008 in_valid  input  1  SHALL qualify in_data and in_last.
REQ-009 in_data  input  DATA_W  SHALL be one registered xpb table output term.
REQ-010 in_last  input  1  SHALL mark the final term of the reduction.
REQ-011 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-012 out_valid  output  1  SHALL be high while a result is held.
REQ-013 out_data  output  OUT_W  SHALL be the accumulated sum.
REQ-014 out_ready  input  1  SHALL be the downstream acceptance of out_data.
REQ-015 err_overflow  output  1  SHALL flag a reduction truncated at MAX_TERMS.

Function
REQ-016 The block SHALL implement three states: IDLE, ACC, HOLD.
REQ-017 IDLE with start=1: acc <= zero-extended lo_in, count <= 0, err_overflow <= 0, next state ACC.
REQ-018 IDLE: in_valid SHALL be ignored; start and in_valid in the same cycle -> start wins and in_data is discarded.
REQ-019 ACC with in_valid=1: acc <= acc + zero-extended in_data (OUT_W-bit add, no modulo), count <= count+1.
REQ-020 ACC with in_valid=1 and in_last=1: next state HOLD.
REQ-021 ACC with in_valid=1, in_last=0, count=MAX_TERMS-1: term accepted, err_overflow <= 1, next state HOLD.
REQ-022 ACC with in_valid=0: acc and count SHALL hold; there is no timeout.
REQ-023 start in ACC or HOLD SHALL be ignored.
REQ-024 HOLD: out_valid=1, out_data=acc; both SHALL stay stable until out_ready=1.
REQ-025 HOLD with out_ready=1: next state IDLE; out_valid low from the following cycle.
REQ-026 HOLD: in_valid SHALL be ignored.
REQ-027 out_valid SHALL rise exactly one cycle after the accepted last (or truncating) term.
REQ-028 out_data SHALL be driven from the acc register, with no combinational path from in_data.
REQ-029 OUT_W SHALL never overflow: lo_in + MAX_TERMS*(2^DATA_W-1) < 2^OUT_W.
REQ-030 err_overflow SHALL stay set through HOLD and IDLE until the next accepted start.
REQ-031 Minimum reduction with one term: start, then term with in_last one or more cycles later, then out_valid on the next cycle.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, acc=0, count=0, busy=0, out_valid=0, out_data=0, err_overflow=0, regardless of clk.
REQ-033 Reset asserted mid-ACC or mid-HOLD SHALL abandon the reduction; after release the block SHALL wait for a new start.

Verification
REQ-034 Reset, then start with lo_in=5, then in_data=3, 7, 9 (last on 9) on consecutive cycles -> out_valid the cycle after 9, out_data=24, err_overflow=0.
REQ-035 Full-scale: lo_in=2^DATA_W-1 and 32 terms of 2^DATA_W-1, last on the 32nd -> out_data=33*(2^DATA_W-1), no wrap, err_overflow=0.
REQ-036 Truncation: 32 terms of 1 with in_last=0 and lo_in=0 -> HOLD after the 32nd term, out_data=32, err_overflow=1; a 33rd in_valid is ignored; err_overflow clears on the next start.
REQ-037 Backpressure and ignores: out_ready held low 10 cycles with start and in_valid toggled -> out_data stable, no state change; out_ready=1 -> IDLE, busy=0.
REQ-038 Gaps and collisions: in_valid gapped randomly -> sum correct; start with in_valid=1, in_data=100 in IDLE -> 100 not added.
REQ-039 rst_n pulsed low asynchronously mid-ACC after 2 terms -> all outputs 0 at once; next start with lo_in=1 and last term 1 -> out_data=2.
